frag_mux_n_pipe: RTL and testbench

- Parametrised N-way data selector with a registered, flow-controlled output stage.
- Successor to the fixed 3-input combinational selector.
- Used in the datapath wherever a selected operand must cross a pipeline boundary under stall: forwarding/bypass selection into EX, and writeback source selection.
- Adds a binary/one-hot select mode, illegal-select detection, and a valid/ready skid buffer so back-pressure never drops or duplicates a beat.

---
 rtl/frag_pkg.sv | 26 ++
 rtl/frag_skid_buf.sv | 55 +++++
 rtl/frag_mux_n_pipe.sv | 98 +++++++++
 tb/tb_frag_mux_n_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frag_pkg.sv
// Shared definitions for the frag_* selector blocks: select-mode constants,
// a minimum-1 clog2 helper and the default beat record.
package frag_pkg;

  localparam int FRAG_MAX_IN   = 16;
  localparam int FRAG_MAX_SELW = 4;
  localparam int FRAG_SEL_BIN  = 0;
  localparam int FRAG_SEL_OH   = 1;

  // Never returns 0, so a 2-input binary select still gets a 1-bit port.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [31:0]              data;
    logic [FRAG_MAX_SELW-1:0] sel_idx;
    logic                     err;
  } frag_beat_t;

endpackage

// File: rtl/frag_skid_buf.sv
// Two-entry valid/ready register slice: an output register plus one skid
// entry, so in_ready is a pure register output with no path from out_ready.
module frag_skid_buf
  import frag_pkg::*;
#(
  parameter type beat_t = frag_beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  beat_t in_beat,
  input  logic  in_valid,
  output logic  in_ready,
  output beat_t out_beat,
  output logic  out_valid,
  input  logic  out_ready
);

  beat_t out_reg;
  beat_t skid_reg;
  logic  out_valid_reg;
  logic  skid_valid_reg;
  logic  accept;
  logic  out_free;

  assign in_ready  = ~skid_valid_reg;
  assign out_beat  = out_reg;
  assign out_valid = out_valid_reg;
  assign accept    = in_valid & ~skid_valid_reg;
  assign out_free  = ~out_valid_reg | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (out_free) begin
      // Skid entry is older than anything arriving now, so it drains first.
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        out_reg       <= in_beat;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg       <= in_beat;
      skid_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/frag_mux_n_pipe.sv
// N-way operand selector (binary or one-hot select) with illegal-select
// detection, feeding a flow-controlled two-entry output slice.
module frag_mux_n_pipe
  import frag_pkg::*;
#(
  parameter int DATAWIDTH  = 32,
  parameter int NUM_IN     = 3,
  parameter int SEL_ONEHOT = 0,
  localparam int SELW      = clog2(NUM_IN),
  localparam int SW        = (SEL_ONEHOT == FRAG_SEL_OH) ? NUM_IN : SELW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_IN*DATAWIDTH-1:0] data_in,
  input  logic [SW-1:0]               select,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [DATAWIDTH-1:0]        data_out,
  output logic [SELW-1:0]             sel_out,
  output logic                        sel_err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [SELW-1:0]      sel_idx;
    logic                 err;
  } beat_t;

  logic [DATAWIDTH-1:0] in_arr [NUM_IN];
  beat_t                dec_beat;
  beat_t                out_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign in_arr[gi] = data_in[gi*DATAWIDTH +: DATAWIDTH];
    end

    if (SEL_ONEHOT == FRAG_SEL_OH) begin : g_onehot
      logic [4:0]           hit_cnt;
      logic [SELW-1:0]      hit_idx;
      logic [DATAWIDTH-1:0] hit_data;

      always_comb begin
        hit_cnt  = '0;
        hit_idx  = '0;
        hit_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
          if (select[k]) begin
            hit_cnt  = hit_cnt + 5'd1;
            hit_idx  = SELW'(k);
            hit_data = in_arr[k];
          end
        end
        dec_beat = '0;
        if (hit_cnt == 5'd1) begin
          dec_beat.data    = hit_data;
          dec_beat.sel_idx = hit_idx;
        end else begin
          dec_beat.err = 1'b1;
        end
      end
    end else begin : g_binary
      // Codes at or above NUM_IN fall through with err set and zero payload.
      always_comb begin
        dec_beat     = '0;
        dec_beat.err = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
          if (select == SELW'(k)) begin
            dec_beat.data    = in_arr[k];
            dec_beat.sel_idx = SELW'(k);
            dec_beat.err     = 1'b0;
          end
        end
      end
    end
  endgenerate

  frag_skid_buf #(
    .beat_t(beat_t)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_beat  (dec_beat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_beat (out_beat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign data_out = out_beat.data;
  assign sel_out  = out_beat.sel_idx;
  assign sel_err  = out_beat.err;

endmodule

// File: tb/tb_frag_mux_n_pipe.sv
// Scoreboard bench: three instances (binary 3-in, one-hot 4-in, binary 16-in)
// checked against a rule-level model of the select decode and FIFO ordering.
module tb_frag_mux_n_pipe;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  bit   rnd_bc = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // Instance A: binary, NUM_IN=3, DATAWIDTH=32
  logic [95:0] a_data_in = '0;
  logic [1:0]  a_sel = '0;
  logic        a_iv = 1'b0, a_ir, a_se, a_ov, a_or = 1'b1;
  logic [31:0] a_do;
  logic [1:0]  a_so;
  // Instance B: one-hot, NUM_IN=4, DATAWIDTH=16
  logic [63:0] b_data_in = '0;
  logic [3:0]  b_sel = '0;
  logic        b_iv = 1'b0, b_ir, b_se, b_ov, b_or = 1'b1;
  logic [15:0] b_do;
  logic [1:0]  b_so;
  // Instance C: binary, NUM_IN=16, DATAWIDTH=8
  logic [127:0] c_data_in = '0;
  logic [3:0]   c_sel = '0;
  logic         c_iv = 1'b0, c_ir, c_se, c_ov, c_or = 1'b1;
  logic [7:0]   c_do;
  logic [3:0]   c_so;

  frag_mux_n_pipe #(.DATAWIDTH(32), .NUM_IN(3), .SEL_ONEHOT(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data_in), .select(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .data_out(a_do), .sel_out(a_so), .sel_err(a_se),
    .out_valid(a_ov), .out_ready(a_or));

  frag_mux_n_pipe #(.DATAWIDTH(16), .NUM_IN(4), .SEL_ONEHOT(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data_in), .select(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .data_out(b_do), .sel_out(b_so), .sel_err(b_se),
    .out_valid(b_ov), .out_ready(b_or));

  frag_mux_n_pipe #(.DATAWIDTH(8), .NUM_IN(16), .SEL_ONEHOT(0)) dut_c (
    .clk(clk), .rst(rst), .data_in(c_data_in), .select(c_sel), .in_valid(c_iv),
    .in_ready(c_ir), .data_out(c_do), .sel_out(c_so), .sel_err(c_se),
    .out_valid(c_ov), .out_ready(c_or));

  exp_t qa[$], qb[$], qc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  bit          a_hold = 0, b_hold = 0, c_hold = 0;
  logic [36:0] a_hold_v, b_hold_v, c_hold_v;

  always @(negedge clk) begin
    exp_t x;
    if (rst) a_hold = 0;
    else begin
      if (a_hold) chk("a_hold_stable", {a_ov, a_do, a_so, a_se}, {1'b1, a_hold_v[35:0]});
      if (a_ov && a_or) begin
        a_hold = 0;
        if (qa.size() == 0) chk("a_unexpected_beat", 1, 0);
        else begin
          x = qa.pop_front();
          chk("a_data", a_do, x.d);
          chk("a_sel", {30'd0, a_so}, {28'd0, x.s});
          chk("a_err", a_se, x.e);
          $display("A beat: data=%08h sel=%0d err=%0d", a_do, a_so, a_se);
        end
      end else if (a_ov) begin
        a_hold = 1; a_hold_v = {1'b0, a_do, a_so, a_se};
      end else a_hold = 0;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rst) b_hold = 0;
    else begin
      if (b_hold) chk("b_hold_stable", {b_ov, b_do, b_so, b_se}, {1'b1, b_hold_v[18:0]});
      if (b_ov && b_or) begin
        b_hold = 0;
        if (qb.size() == 0) chk("b_unexpected_beat", 1, 0);
        else begin
          x = qb.pop_front();
          chk("b_data", b_do, x.d);
          chk("b_sel", b_so, x.s);
          chk("b_err", b_se, x.e);
          $display("B beat: data=%04h sel=%0d err=%0d", b_do, b_so, b_se);
        end
      end else if (b_ov) begin
        b_hold = 1; b_hold_v = {18'd0, b_do, b_so, b_se};
      end else b_hold = 0;
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (rst) c_hold = 0;
    else begin
      if (c_hold) chk("c_hold_stable", {c_ov, c_do, c_so, c_se}, {1'b1, c_hold_v[12:0]});
      if (c_ov && c_or) begin
        c_hold = 0;
        if (qc.size() == 0) chk("c_unexpected_beat", 1, 0);
        else begin
          x = qc.pop_front();
          chk("c_data", c_do, x.d);
          chk("c_sel", c_so, x.s);
          chk("c_err", c_se, x.e);
          $display("C beat: data=%02h sel=%0d err=%0d", c_do, c_so, c_se);
        end
      end else if (c_ov) begin
        c_hold = 1; c_hold_v = {24'd0, c_do, c_so, c_se};
      end else c_hold = 0;
    end
  end

  always @(posedge clk) begin
    if (rnd_bc) begin
      #2;
      b_or = 1'($urandom_range(0, 1));
      c_or = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- drivers (enter and leave at posedge+1, in_valid left high) ----------------
  task automatic send_a(input logic [95:0] d, input logic [1:0] s);
    exp_t x; bit acc; int n = 0;
    a_data_in = d; a_sel = s; a_iv = 1'b1;
    x.e = (s >= 2'd3);
    x.s = x.e ? 4'd0 : {2'b0, s};
    x.d = x.e ? 32'd0 : ((s == 2'd0) ? d[31:0] : (s == 2'd1) ? d[63:32] : d[95:64]);
    forever begin
      acc = a_ir;
      if (acc) qa.push_back(x);
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 200) begin chk("a_accept_timeout", 0, 1); break; end
    end
  endtask

  task automatic send_b(input logic [63:0] d, input logic [3:0] s);
    exp_t x; bit acc; int n = 0; int idx;
    b_data_in = d; b_sel = s; b_iv = 1'b1;
    x.e = ($countones(s) != 1);
    idx = $clog2(s);
    x.s = x.e ? 4'd0 : 4'(idx);
    x.d = x.e ? 32'd0 : {16'd0, d[idx*16 +: 16]};
    forever begin
      acc = b_ir;
      if (acc) qb.push_back(x);
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 200) begin chk("b_accept_timeout", 0, 1); break; end
    end
  endtask

  task automatic send_c(input logic [127:0] d, input logic [3:0] s);
    exp_t x; bit acc; int n = 0;
    c_data_in = d; c_sel = s; c_iv = 1'b1;
    x.e = 1'b0; x.s = s; x.d = {24'd0, d[s*8 +: 8]};
    forever begin
      acc = c_ir;
      if (acc) qc.push_back(x);
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 200) begin chk("c_accept_timeout", 0, 1); break; end
    end
  endtask

  task automatic drain();
    int n = 0;
    rnd_bc = 1'b0;
    a_iv = 0; b_iv = 0; c_iv = 0;
    @(posedge clk); #1;
    a_or = 1; b_or = 1; c_or = 1;
    while (qa.size() + qb.size() + qc.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_queues_empty", qa.size() + qb.size() + qc.size(), 0);
  endtask

  initial begin
    int sent, t0;
    bit acc, done;
    logic [127:0] cd;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", a_ov, 0);
    chk("reset_data_out", a_do, 0);
    chk("reset_sel_out", a_so, 0);
    chk("reset_sel_err", a_se, 0);
    chk("reset_in_ready", a_ir, 1);

    // First beat: latency one cycle
    send_a({32'h33, 32'h22, 32'h11}, 2'd2);
    a_iv = 0;
    chk("first_latency_valid", a_ov, 1);
    chk("first_latency_data", a_do, 32'h33);
    send_a({32'h33, 32'h22, 32'h11}, 2'd3);
    for (int i = 0; i < 10; i++) send_a({$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
    drain();

    // Back-pressure: 4 beats, out_ready low for 3 cycles
    a_or = 0; a_iv = 1; sent = 0;
    for (int cyc = 0; cyc < 12 && sent < 4; cyc++) begin
      a_data_in = {64'd0, 32'(sent + 1)}; a_sel = 2'd0;
      if (cyc == 3) a_or = 1;
      if (cyc >= 3) chk("bp_no_gap", a_ov, 1);
      acc = a_ir;
      if (acc) qa.push_back('{d: 32'(sent + 1), s: 4'd0, e: 1'b0});
      @(posedge clk); #1;
      if (acc) sent++;
      if (cyc == 2) begin
        chk("bp_accepts_before_stall", sent, 2);
        chk("bp_in_ready_dropped", a_ir, 0);
      end
    end
    a_iv = 0;
    chk("bp_no_gap_last", a_ov, 1);
    drain();

    // Alternating out_ready over 20 beats
    done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send_a({$urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
        a_iv = 0; done = 1;
      end
      begin
        logic r0;
        while (!done) begin
          @(posedge clk); #2;
          r0 = a_ir;
          a_or = ~a_or;
          #1 chk("in_ready_indep_of_out_ready", a_ir, r0);
        end
      end
    join
    drain();

    // One-hot instance
    send_b({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b0110);
    send_b({16'h4444, 16'h3333, 16'h2222, 16'h1111}, 4'b0100);
    rnd_bc = 1'b1;
    for (int i = 0; i < 20; i++) send_b({$urandom, $urandom}, 4'($urandom_range(0, 15)));
    drain();

    // 16-input sweep at full rate
    for (int k = 0; k < 16; k++) cd[k*8 +: 8] = 8'($urandom);
    t0 = cyc_cnt;
    for (int k = 0; k < 16; k++) send_c(cd, 4'(k));
    c_iv = 0;
    chk("sweep_one_beat_per_cycle", cyc_cnt - t0, 16);
    rnd_bc = 1'b1;
    for (int i = 0; i < 20; i++) send_c({$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
    drain();

    // Reset with both entries full
    a_or = 0;
    send_a({32'h0, 32'hBB, 32'hAA}, 2'd0);
    send_a({32'h0, 32'hBB, 32'hAA}, 2'd1);
    chk("full_in_ready_low", a_ir, 0);
    a_data_in = {32'h0, 32'h0, 32'hCC}; a_sel = 2'd0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; a_iv = 0;
    qa.delete(); qb.delete(); qc.delete();
    chk("midreset_out_valid", a_ov, 0);
    chk("midreset_in_ready", a_ir, 1);
    chk("midreset_outputs", {a_do, a_so, a_se}, 0);
    a_or = 1;
    send_a({32'h0, 32'h0, 32'h5A5A}, 2'd0);
    a_iv = 0;
    chk("post_reset_delivery_data", a_do, 32'h5A5A);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
